// File: rtl/reservation_station_pkg.sv
// Shared types and sizes for the ALU reservation station.
// Entry layout, operand tag/value pairs and the broadcast snoop helper.
package reservation_station_pkg;

    localparam int RS_SIZE   = 16;
    localparam int RS_IDX_W  = $clog2(RS_SIZE);
    localparam int DATA_W    = 32;
    localparam int ROB_POS_W = 5;
    localparam int OPENUM_W  = 6;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ROB_POS_W-1:0] rob_pos_t;
    typedef logic [OPENUM_W-1:0]  openum_t;
    typedef logic [RS_IDX_W-1:0]  rs_idx_t;
    typedef logic [RS_IDX_W:0]    rs_cnt_t;

    // Operand is ready when q == 0; v is meaningful only then.
    typedef struct packed {
        rob_pos_t q;
        data_t    v;
    } operand_t;

    typedef struct packed {
        logic     valid;
        openum_t  openum;
        operand_t op1;
        operand_t op2;
        data_t    imm;
        data_t    pc;
        rob_pos_t rob_pos;
    } rs_entry_t;

    // Resolve a pending operand against the ALU and load broadcasts.
    // ALU wins if both match; tag 0 never matches anything.
    function automatic operand_t snoop(
        input operand_t op,
        input logic     a_rdy,
        input rob_pos_t a_tag,
        input data_t    a_val,
        input logic     l_rdy,
        input rob_pos_t l_tag,
        input data_t    l_val
    );
        operand_t r;
        r = op;
        if (op.q != '0) begin
            if (a_rdy && a_tag == op.q) begin
                r.q = '0;
                r.v = a_val;
            end else if (l_rdy && l_tag == op.q) begin
                r.q = '0;
                r.v = l_val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority pick for free and dispatch-ready entries.
// Pure combinational; one instance serves both allocate and dispatch.
module rs_select
    import reservation_station_pkg::*;
(
    input  logic [RS_SIZE-1:0] valid,
    input  logic [RS_SIZE-1:0] ready,
    output rs_idx_t            free_idx,
    output logic               free_found,
    output rs_idx_t            ready_idx,
    output logic               ready_found
);

    // Scan high to low so the last hit is the lowest index.
    always_comb begin
        free_idx    = '0;
        free_found  = FALSE;
        ready_idx   = '0;
        ready_found = FALSE;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = TRUE;
                free_idx   = rs_idx_t'(i);
            end
            if (ready[i]) begin
                ready_found = TRUE;
                ready_idx   = rs_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order buffer for ALU-class ops between decoder and ALU.
// Allocates on issue, wakes operands on broadcasts, dispatches one per cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 rs_enable,
    input  logic [OPENUM_W-1:0]  issue_openum,
    input  logic [DATA_W-1:0]    issue_rs1_val,
    input  logic [ROB_POS_W-1:0] issue_rs1_rob_pos,
    input  logic [DATA_W-1:0]    issue_rs2_val,
    input  logic [ROB_POS_W-1:0] issue_rs2_rob_pos,
    input  logic [DATA_W-1:0]    issue_imm,
    input  logic [DATA_W-1:0]    issue_pc,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    input  logic                 alu_result_ready,
    input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
    input  logic [DATA_W-1:0]    alu_result_val,
    input  logic                 lsb_load_result_ready,
    input  logic [ROB_POS_W-1:0] lsb_load_result_rob_pos,
    input  logic [DATA_W-1:0]    lsb_load_result_val,
    output logic                 rs_full,
    output logic                 alu_enable,
    output logic [OPENUM_W-1:0]  alu_openum,
    output logic [DATA_W-1:0]    alu_rs1_val,
    output logic [DATA_W-1:0]    alu_rs2_val,
    output logic [DATA_W-1:0]    alu_imm,
    output logic [DATA_W-1:0]    alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos
);

    rs_entry_t ent_q [RS_SIZE];
    rs_entry_t ent_d [RS_SIZE];
    rs_cnt_t   count_q;
    rs_cnt_t   count_d;

    logic [RS_SIZE-1:0] valid_vec;
    logic [RS_SIZE-1:0] ready_vec;
    rs_idx_t            free_idx;
    rs_idx_t            ready_idx;
    logic               free_found;
    logic               ready_found;
    logic               do_alloc;

    // Occupancy and readiness seen by the selector, from registered state only.
    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            valid_vec[i] = ent_q[i].valid;
            ready_vec[i] = ent_q[i].valid
                         && ent_q[i].op1.q == '0
                         && ent_q[i].op2.q == '0;
        end
    end

    rs_select u_select (
        .valid       (valid_vec),
        .ready       (ready_vec),
        .free_idx    (free_idx),
        .free_found  (free_found),
        .ready_idx   (ready_idx),
        .ready_found (ready_found)
    );

    assign do_alloc = rs_enable && free_found;

    // Next entry state: wakeup, free the dispatched slot, write the new bundle.
    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;
        if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].valid) begin
                    ent_d[i].op1 = snoop(ent_q[i].op1,
                        alu_result_ready, alu_result_rob_pos, alu_result_val,
                        lsb_load_result_ready, lsb_load_result_rob_pos,
                        lsb_load_result_val);
                    ent_d[i].op2 = snoop(ent_q[i].op2,
                        alu_result_ready, alu_result_rob_pos, alu_result_val,
                        lsb_load_result_ready, lsb_load_result_rob_pos,
                        lsb_load_result_val);
                end
            end
            if (ready_found) begin
                ent_d[ready_idx].valid = FALSE;
            end
            if (do_alloc) begin
                ent_d[free_idx].valid   = TRUE;
                ent_d[free_idx].openum  = issue_openum;
                ent_d[free_idx].op1     = snoop(
                    '{q: issue_rs1_rob_pos, v: issue_rs1_val},
                    alu_result_ready, alu_result_rob_pos, alu_result_val,
                    lsb_load_result_ready, lsb_load_result_rob_pos,
                    lsb_load_result_val);
                ent_d[free_idx].op2     = snoop(
                    '{q: issue_rs2_rob_pos, v: issue_rs2_val},
                    alu_result_ready, alu_result_rob_pos, alu_result_val,
                    lsb_load_result_ready, lsb_load_result_rob_pos,
                    lsb_load_result_val);
                ent_d[free_idx].imm     = issue_imm;
                ent_d[free_idx].pc      = issue_pc;
                ent_d[free_idx].rob_pos = issue_rob_pos;
            end
            count_d = count_q + rs_cnt_t'(do_alloc)
                              - rs_cnt_t'(ready_found);
        end
    end

    // Entry array and occupancy registers; flush drops every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i].valid <= FALSE;
            end
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
        end
    end

    // Registered dispatch port; payload holds when nothing is selected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_enable  <= FALSE;
            alu_openum  <= '0;
            alu_rs1_val <= '0;
            alu_rs2_val <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (clr || !rdy) begin
            alu_enable <= FALSE;
        end else if (ready_found) begin
            alu_enable  <= TRUE;
            alu_openum  <= ent_q[ready_idx].openum;
            alu_rs1_val <= ent_q[ready_idx].op1.v;
            alu_rs2_val <= ent_q[ready_idx].op2.v;
            alu_imm     <= ent_q[ready_idx].imm;
            alu_pc      <= ent_q[ready_idx].pc;
            alu_rob_pos <= ent_q[ready_idx].rob_pos;
        end else begin
            alu_enable <= FALSE;
        end
    end

    // One slack entry covers the fetch-side decision latency.
    assign rs_full = (count_q >= rs_cnt_t'(RS_SIZE - 1));

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station.
// Dispatches are matched in order against a queue of expected bundles.
module tb_reservation_station;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        rs_enable;
    logic [5:0]  issue_openum;
    logic [31:0] issue_rs1_val;
    logic [4:0]  issue_rs1_rob_pos;
    logic [31:0] issue_rs2_val;
    logic [4:0]  issue_rs2_rob_pos;
    logic [31:0] issue_imm;
    logic [31:0] issue_pc;
    logic [4:0]  issue_rob_pos;
    logic        alu_result_ready;
    logic [4:0]  alu_result_rob_pos;
    logic [31:0] alu_result_val;
    logic        lsb_load_result_ready;
    logic [4:0]  lsb_load_result_rob_pos;
    logic [31:0] lsb_load_result_val;
    logic        rs_full;
    logic        alu_enable;
    logic [5:0]  alu_openum;
    logic [31:0] alu_rs1_val;
    logic [31:0] alu_rs2_val;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [4:0]  alu_rob_pos;

    reservation_station dut (
        .clk                     (clk),
        .rst                     (rst),
        .rdy                     (rdy),
        .clr                     (clr),
        .rs_enable               (rs_enable),
        .issue_openum            (issue_openum),
        .issue_rs1_val           (issue_rs1_val),
        .issue_rs1_rob_pos       (issue_rs1_rob_pos),
        .issue_rs2_val           (issue_rs2_val),
        .issue_rs2_rob_pos       (issue_rs2_rob_pos),
        .issue_imm               (issue_imm),
        .issue_pc                (issue_pc),
        .issue_rob_pos           (issue_rob_pos),
        .alu_result_ready        (alu_result_ready),
        .alu_result_rob_pos      (alu_result_rob_pos),
        .alu_result_val          (alu_result_val),
        .lsb_load_result_ready   (lsb_load_result_ready),
        .lsb_load_result_rob_pos (lsb_load_result_rob_pos),
        .lsb_load_result_val     (lsb_load_result_val),
        .rs_full                 (rs_full),
        .alu_enable              (alu_enable),
        .alu_openum              (alu_openum),
        .alu_rs1_val             (alu_rs1_val),
        .alu_rs2_val             (alu_rs2_val),
        .alu_imm                 (alu_imm),
        .alu_pc                  (alu_pc),
        .alu_rob_pos             (alu_rob_pos)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rob;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  q1;
        logic [31:0] v1;
        logic [4:0]  q2;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rob;
        logic        alu_bc;
        logic        lsb_bc;
        logic [4:0]  bc_tag;
        logic [31:0] bc_val;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Every dispatch must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && alu_enable === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_dispatch: got rob %0d, required none",
                         alu_rob_pos);
            end else begin
                e = sb.pop_front();
                chk("disp_op", 32'(alu_openum), 32'(e.op));
                chk("disp_rs1", alu_rs1_val, e.rs1);
                chk("disp_rs2", alu_rs2_val, e.rs2);
                chk("disp_imm", alu_imm, e.imm);
                chk("disp_pc", alu_pc, e.pc);
                chk("disp_rob", 32'(alu_rob_pos), 32'(e.rob));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        rs_enable             = 1'b0;
        clr                   = 1'b0;
        alu_result_ready      = 1'b0;
        lsb_load_result_ready = 1'b0;
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [4:0] q1,
                             input logic [31:0] v1, input logic [4:0] q2,
                             input logic [31:0] v2, input logic [31:0] imm,
                             input logic [31:0] pc, input logic [4:0] rob);
        rs_enable         = 1'b1;
        issue_openum      = op;
        issue_rs1_rob_pos = q1;
        issue_rs1_val     = v1;
        issue_rs2_rob_pos = q2;
        issue_rs2_val     = v2;
        issue_imm         = imm;
        issue_pc          = pc;
        issue_rob_pos     = rob;
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rob);
        exp_t e;
        e.op  = op;
        e.rs1 = rs1;
        e.rs2 = rs2;
        e.imm = imm;
        e.pc  = pc;
        e.rob = rob;
        sb.push_back(e);
    endtask

    task automatic alu_bc(input logic [4:0] tag, input logic [31:0] val);
        alu_result_ready   = 1'b1;
        alu_result_rob_pos = tag;
        alu_result_val     = val;
    endtask

    task automatic lsb_bc(input logic [4:0] tag, input logic [31:0] val);
        lsb_load_result_ready   = 1'b1;
        lsb_load_result_rob_pos = tag;
        lsb_load_result_val     = val;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        tbl[0] = '{6'd1, 5'd0, 32'h11, 5'd0, 32'h22, 32'h100, 32'h1000, 5'd1,
                   1'b1, 1'b0, 5'd0, 32'hdead, 32'h11, 32'h22};
        tbl[1] = '{6'd2, 5'd3, 32'h0, 5'd0, 32'h44, 32'h4, 32'h1004, 5'd2,
                   1'b1, 1'b0, 5'd3, 32'hcafe, 32'hcafe, 32'h44};
        tbl[2] = '{6'd3, 5'd0, 32'h55, 5'd5, 32'h0, 32'h8, 32'h1008, 5'd3,
                   1'b0, 1'b1, 5'd5, 32'hbeef, 32'h55, 32'hbeef};
        tbl[3] = '{6'd4, 5'd2, 32'h0, 5'd2, 32'h0, 32'hc, 32'h100c, 5'd4,
                   1'b1, 1'b0, 5'd2, 32'h1357, 32'h1357, 32'h1357};
        tbl[4] = '{6'd5, 5'd0, 32'hffffffff, 5'd0, 32'h0, 32'hfffff000,
                   32'hfffffffc, 5'd31, 1'b0, 1'b0, 5'd0, 32'h0,
                   32'hffffffff, 32'h0};
        tbl[5] = '{6'd63, 5'd8, 32'h0, 5'd0, 32'h7, 32'h14, 32'h1014, 5'd8,
                   1'b0, 1'b1, 5'd8, 32'h88, 32'h88, 32'h7};

        rst = 1'b0;
        rdy = 1'b1;
        clr = 1'b0;
        rs_enable = 1'b0;
        issue_openum = '0;
        issue_rs1_val = '0;
        issue_rs1_rob_pos = '0;
        issue_rs2_val = '0;
        issue_rs2_rob_pos = '0;
        issue_imm = '0;
        issue_pc = '0;
        issue_rob_pos = '0;
        alu_result_ready = 1'b0;
        alu_result_rob_pos = '0;
        alu_result_val = '0;
        lsb_load_result_ready = 1'b0;
        lsb_load_result_rob_pos = '0;
        lsb_load_result_val = '0;

        repeat (2) @(negedge clk);
        chk("rst_alu_enable", 32'(alu_enable), 32'd0);
        chk("rst_rs_full", 32'(rs_full), 32'd0);
        chk("rst_alu_rs1", alu_rs1_val, 32'd0);
        chk("rst_alu_rob", 32'(alu_rob_pos), 32'd0);
        rst = 1'b1;
        step();

        // Back-to-back issues, with same-cycle broadcast snooping.
        for (int i = 0; i < 6; i++) begin
            set_issue(tbl[i].op, tbl[i].q1, tbl[i].v1, tbl[i].q2, tbl[i].v2,
                      tbl[i].imm, tbl[i].pc, tbl[i].rob);
            if (tbl[i].alu_bc) alu_bc(tbl[i].bc_tag, tbl[i].bc_val);
            if (tbl[i].lsb_bc) lsb_bc(tbl[i].bc_tag, tbl[i].bc_val);
            push(tbl[i].op, tbl[i].e1, tbl[i].e2, tbl[i].imm, tbl[i].pc,
                 tbl[i].rob);
            step();
        end
        wait_drain("table_drain", 10);
        step();

        // Ready issue latency.
        set_issue(6'd7, 5'd0, 32'd5, 5'd0, 32'd7, 32'h0, 32'h2000, 5'd3);
        push(6'd7, 32'd5, 32'd7, 32'h0, 32'h2000, 5'd3);
        step();
        chk("lat_issue_edge", 32'(alu_enable), 32'd0);
        step();
        chk("lat_next_edge", 32'(alu_enable), 32'd1);
        step();
        chk("no_double_disp", 32'(alu_enable), 32'd0);
        chk("count_back_0", 32'(rs_full), 32'd0);

        // ALU wakeup.
        set_issue(6'd8, 5'd4, 32'h0, 5'd0, 32'd9, 32'h10, 32'h2004, 5'd10);
        step();
        step();
        chk("wait_no_disp", 32'(alu_enable), 32'd0);
        push(6'd8, 32'h1234, 32'd9, 32'h10, 32'h2004, 5'd10);
        alu_bc(5'd4, 32'h1234);
        step();
        chk("wake_edge", 32'(alu_enable), 32'd0);
        step();
        chk("wake_disp", 32'(alu_enable), 32'd1);
        step();

        // Load wakeup of two entries; lowest index first.
        set_issue(6'd9, 5'd6, 32'h0, 5'd0, 32'd1, 32'h20, 32'h2008, 5'd11);
        step();
        set_issue(6'd9, 5'd6, 32'h0, 5'd0, 32'd2, 32'h24, 32'h200c, 5'd12);
        step();
        push(6'd9, 32'hab, 32'd1, 32'h20, 32'h2008, 5'd11);
        push(6'd9, 32'hab, 32'd2, 32'h24, 32'h200c, 5'd12);
        lsb_bc(5'd6, 32'hab);
        step();
        step();
        chk("load_disp0", 32'(alu_rob_pos), 32'd11);
        step();
        chk("load_disp1", 32'(alu_rob_pos), 32'd12);
        step();
        chk("load_done", 32'(alu_enable), 32'd0);

        // Fill to capacity: full at 15, still full at 16.
        for (int k = 0; k < 16; k++) begin
            set_issue(6'd10, 5'd7, 32'h0, 5'd0, 32'(k), 32'(k),
                      32'h3000 + 32'(4 * k), 5'(k + 1));
            push(6'd10, 32'h77, 32'(k), 32'(k), 32'h3000 + 32'(4 * k),
                 5'(k + 1));
            step();
            if (k == 13) chk("full_at_14", 32'(rs_full), 32'd0);
            if (k == 14) chk("full_at_15", 32'(rs_full), 32'd1);
            if (k == 15) chk("full_at_16", 32'(rs_full), 32'd1);
        end
        alu_bc(5'd7, 32'h77);
        step();
        chk("full_wake_edge", 32'(rs_full), 32'd1);
        step();
        chk("full_after_1", 32'(rs_full), 32'd1);
        step();
        chk("full_after_2", 32'(rs_full), 32'd0);
        wait_drain("full_drain", 20);
        step();

        // Flush with same-cycle issue and broadcast.
        for (int k = 0; k < 8; k++) begin
            set_issue(6'd11, 5'd9, 32'h0, 5'd0, 32'h0, 32'h0, 32'h4000,
                      5'(20 + k));
            step();
        end
        set_issue(6'd12, 5'd0, 32'h1, 5'd0, 32'h2, 32'h0, 32'h4100, 5'd29);
        alu_bc(5'd9, 32'h99);
        clr = 1'b1;
        step();
        chk("clr_alu_enable", 32'(alu_enable), 32'd0);
        chk("clr_rs_full", 32'(rs_full), 32'd0);
        alu_bc(5'd9, 32'h99);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("clr_no_disp", 32'(alu_enable), 32'd0);
        end

        // Freeze with a ready entry: nothing moves, payload holds.
        set_issue(6'd13, 5'd0, 32'h30, 5'd0, 32'h31, 32'h32, 32'h5000, 5'd30);
        push(6'd13, 32'h30, 32'h31, 32'h32, 32'h5000, 5'd30);
        step();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("frz_enable", 32'(alu_enable), 32'd0);
            chk("frz_hold_rob", 32'(alu_rob_pos), 32'd16);
        end
        rdy = 1'b1;
        step();
        chk("frz_release", 32'(alu_enable), 32'd1);
        step();

        // Asynchronous reset mid-cycle clears outputs and pending entries.
        set_issue(6'd14, 5'd12, 32'h0, 5'd0, 32'h0, 32'h0, 32'h6000, 5'd5);
        step();
        set_issue(6'd15, 5'd0, 32'h41, 5'd0, 32'h42, 32'h43, 32'h6004, 5'd31);
        push(6'd15, 32'h41, 32'h42, 32'h43, 32'h6004, 5'd31);
        step();
        step();
        chk("pre_rst_enable", 32'(alu_enable), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_enable", 32'(alu_enable), 32'd0);
        chk("arst_rs1", alu_rs1_val, 32'd0);
        chk("arst_rob", 32'(alu_rob_pos), 32'd0);
        chk("arst_op", 32'(alu_openum), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        alu_bc(5'd12, 32'h12);
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("arst_no_disp", 32'(alu_enable), 32'd0);
        end

        wait_drain("final_drain", 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
